// File: rtl/encoder_fault_monitor_if.sv
// Signal bundle between a priority encoder under observation and its fault monitor.
// Carries the sampled encoder inputs and outputs and the monitor's status and capture fields.
// master: the side that drives the observed encoder signals; slave: the monitor itself.
interface encoder_fault_monitor_if #(
  parameter int N     = 8,
  parameter int CNT_W = 16
);
  localparam int W = $clog2(N);

  // Observed encoder signals plus control strobes
  logic             en;
  logic             clear_fault;
  logic [N-1:0]     d;
  logic [W-1:0]     y_dut;
  logic             v_dut;

  // Monitor status and first-fault capture
  logic             mismatch;
  logic             fault_detected;
  logic [1:0]       fault_state;
  logic [CNT_W-1:0] err_count;
  logic             cap_valid;
  logic [N-1:0]     cap_d;
  logic [W-1:0]     cap_y_dut;
  logic [W-1:0]     cap_y_gold;

  modport master (
    output en, clear_fault, d, y_dut, v_dut,
    input  mismatch, fault_detected, fault_state, err_count,
    input  cap_valid, cap_d, cap_y_dut, cap_y_gold
  );

  modport slave (
    input  en, clear_fault, d, y_dut, v_dut,
    output mismatch, fault_detected, fault_state, err_count,
    output cap_valid, cap_d, cap_y_dut, cap_y_gold
  );
endinterface

// File: rtl/encoder_fault_monitor.sv
// Purpose: checks an N-input priority encoder against an internal golden model and declares a
//          sticky fault after PERSIST consecutive mismatching enabled samples.
// Latency: a sample taken at an enabled edge is reflected in every output right after that edge.
// Backpressure: none; a passive observer that accepts a sample on every en=1 cycle.
// Ports: clk, rst (sync, active-high); mon (slave) carries en, clear_fault, d, y_dut, v_dut in and
//        mismatch, fault_detected, fault_state, err_count, cap_valid/cap_d/cap_y_dut/cap_y_gold out.
module encoder_fault_monitor #(
  parameter int N       = 8,
  parameter int PERSIST = 2,
  parameter int CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  encoder_fault_monitor_if.slave mon
);

  localparam int W     = $clog2(N);
  localparam int RUN_W = $clog2(PERSIST + 1);

  localparam logic [RUN_W-1:0] RUN_ONE   = RUN_W'(1);
  localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(PERSIST);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_SUSPECT = 2'd1,
    ST_FAULT   = 2'd2,
    ST_ILLEGAL = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             mismatch_q, mismatch_d;
  logic             fault_detected_q, fault_detected_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic             cap_valid_q, cap_valid_d;
  logic [N-1:0]     cap_d_q, cap_d_d;
  logic [W-1:0]     cap_y_dut_q, cap_y_dut_d;
  logic [W-1:0]     cap_y_gold_q, cap_y_gold_d;

  logic             gold_v;
  logic [W-1:0]     gold_y;
  logic             sample_mis;
  logic             enter_fault;

  // Golden encoder: the ascending scan leaves the highest set bit's index in gold_y.
  always_comb begin
    gold_v = |mon.d;
    gold_y = '0;
    for (int i = 0; i < N; i++) begin
      if (mon.d[i]) begin
        gold_y = W'(i);
      end
    end
  end

  // y_dut only matters when the golden valid is set.
  assign sample_mis = (mon.v_dut != gold_v) || (gold_v && (mon.y_dut != gold_y));

  // Next-state and datapath
  always_comb begin
    state_d          = state_q;
    run_d            = run_q;
    mismatch_d       = mismatch_q;
    err_count_d      = err_count_q;
    cap_valid_d      = cap_valid_q;
    cap_d_d          = cap_d_q;
    cap_y_dut_d      = cap_y_dut_q;
    cap_y_gold_d     = cap_y_gold_q;
    enter_fault      = 1'b0;

    if (mon.en) begin
      mismatch_d = sample_mis;
      if (sample_mis && (err_count_q != CNT_MAX)) begin
        err_count_d = err_count_q + CNT_ONE;
      end
    end

    unique case (state_q)
      ST_OK: begin
        if (mon.en) begin
          if (sample_mis) begin
            run_d = RUN_ONE;
            if (PERSIST == 1) begin
              state_d     = ST_FAULT;
              enter_fault = 1'b1;
            end else begin
              state_d = ST_SUSPECT;
            end
          end else begin
            run_d = '0;
          end
        end
      end
      ST_SUSPECT: begin
        if (mon.en) begin
          if (sample_mis) begin
            run_d = run_q + RUN_ONE;
            if ((run_q + RUN_ONE) == RUN_LIMIT) begin
              state_d     = ST_FAULT;
              enter_fault = 1'b1;
            end
          end else begin
            state_d = ST_OK;
            run_d   = '0;
          end
        end
      end
      ST_FAULT: begin
        // Clear wins over a coincident mismatch; the sample is still counted above.
        if (mon.clear_fault) begin
          state_d = ST_OK;
          run_d   = '0;
        end
      end
      default: begin
        state_d = ST_OK;
        run_d   = '0;
      end
    endcase

    // Only the first fault since reset is captured.
    if (enter_fault && !cap_valid_q) begin
      cap_valid_d  = 1'b1;
      cap_d_d      = mon.d;
      cap_y_dut_d  = mon.y_dut;
      cap_y_gold_d = gold_y;
    end

    fault_detected_d = (state_d == ST_FAULT);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_OK;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      run_q            <= '0;
      mismatch_q       <= 1'b0;
      fault_detected_q <= 1'b0;
      err_count_q      <= '0;
      cap_valid_q      <= 1'b0;
      cap_d_q          <= '0;
      cap_y_dut_q      <= '0;
      cap_y_gold_q     <= '0;
    end else begin
      run_q            <= run_d;
      mismatch_q       <= mismatch_d;
      fault_detected_q <= fault_detected_d;
      err_count_q      <= err_count_d;
      cap_valid_q      <= cap_valid_d;
      cap_d_q          <= cap_d_d;
      cap_y_dut_q      <= cap_y_dut_d;
      cap_y_gold_q     <= cap_y_gold_d;
    end
  end

  assign mon.mismatch       = mismatch_q;
  assign mon.fault_detected = fault_detected_q;
  assign mon.fault_state    = state_q;
  assign mon.err_count      = err_count_q;
  assign mon.cap_valid      = cap_valid_q;
  assign mon.cap_d          = cap_d_q;
  assign mon.cap_y_dut      = cap_y_dut_q;
  assign mon.cap_y_gold     = cap_y_gold_q;

endmodule

// File: tb/tb_encoder_fault_monitor.sv
// Bench for encoder_fault_monitor: two instances (16-bit and 3-bit error counters) share stimulus
// and are compared every cycle against a behavioural model, plus directed literal checks.
module tb_encoder_fault_monitor;

  localparam int N       = 8;
  localparam int PERSIST = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  encoder_fault_monitor_if #(.N(N), .CNT_W(16)) ifa ();
  encoder_fault_monitor_if #(.N(N), .CNT_W(3))  ifb ();

  assign ifb.en          = ifa.en;
  assign ifb.clear_fault = ifa.clear_fault;
  assign ifb.d           = ifa.d;
  assign ifb.y_dut       = ifa.y_dut;
  assign ifb.v_dut       = ifa.v_dut;

  encoder_fault_monitor #(.N(N), .PERSIST(PERSIST), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .mon(ifa)
  );

  encoder_fault_monitor #(.N(N), .PERSIST(PERSIST), .CNT_W(3)) dut_b (
    .clk(clk), .rst(rst), .mon(ifb)
  );

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Fault = sticky flag; run = length of the current streak of mismatching enabled samples.
  bit       m_mis;
  bit       m_fault;
  int       m_run;
  int       m_total;
  bit       m_capv;
  bit [7:0] m_capd;
  int       m_capyd;
  int       m_capyg;

  function automatic int gold_idx(input bit [7:0] dv);
    int y = 0;
    int v = int'(dv);
    while (v > 1) begin
      v = v / 2;
      y++;
    end
    return y;
  endfunction

  always @(posedge clk) begin
    bit was_fault;
    bit mis;
    if (rst) begin
      m_mis = 0; m_fault = 0; m_run = 0; m_total = 0;
      m_capv = 0; m_capd = 0; m_capyd = 0; m_capyg = 0;
    end else begin
      was_fault = m_fault;
      if (ifa.en) begin
        if (ifa.d == 0) mis = (ifa.v_dut != 1'b0);
        else mis = (ifa.v_dut != 1'b1) || (int'(ifa.y_dut) != gold_idx(ifa.d));
        m_mis = mis;
        if (mis) begin
          m_total++;
          m_run++;
        end else begin
          m_run = 0;
        end
        if (!m_fault && m_run >= PERSIST) begin
          m_fault = 1;
          if (!m_capv) begin
            m_capv  = 1;
            m_capd  = ifa.d;
            m_capyd = int'(ifa.y_dut);
            m_capyg = gold_idx(ifa.d);
          end
        end
      end
      if (was_fault && ifa.clear_fault) begin
        m_fault = 0;
        m_run   = 0;
      end
    end
  end

  function automatic int exp_state();
    return m_fault ? 2 : ((m_run > 0) ? 1 : 0);
  endfunction

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("a_mismatch",    32'(ifa.mismatch),       32'(m_mis));
      chk("a_fault_det",   32'(ifa.fault_detected), 32'(m_fault));
      chk("a_state",       32'(ifa.fault_state),    32'(exp_state()));
      chk("a_err_count",   32'(ifa.err_count),      32'((m_total > 65535) ? 65535 : m_total));
      chk("a_cap_valid",   32'(ifa.cap_valid),      32'(m_capv));
      chk("a_cap_d",       32'(ifa.cap_d),          32'(m_capd));
      chk("a_cap_y_dut",   32'(ifa.cap_y_dut),      32'(m_capyd));
      chk("a_cap_y_gold",  32'(ifa.cap_y_gold),     32'(m_capyg));
      chk("b_mismatch",    32'(ifb.mismatch),       32'(m_mis));
      chk("b_state",       32'(ifb.fault_state),    32'(exp_state()));
      chk("b_err_count",   32'(ifb.err_count),      32'((m_total > 7) ? 7 : m_total));
      chk("b_cap_d",       32'(ifb.cap_d),          32'(m_capd));
    end
  end

  // ---------------- stimulus ----------------
  task automatic apply(input bit r, input bit e, input bit c,
                       input logic [7:0] dd, input logic [2:0] yy, input bit vv);
    @(negedge clk);
    rst             = r;
    ifa.en          = e;
    ifa.clear_fault = c;
    ifa.d           = dd;
    ifa.y_dut       = yy;
    ifa.v_dut       = vv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] rd;
    logic [2:0] ry;
    bit         rv;

    ifa.en = 0; ifa.clear_fault = 0; ifa.d = '0; ifa.y_dut = '0; ifa.v_dut = 0;

    // Reset and match
    apply(1, 0, 0, 8'h00, 3'd0, 0);
    apply(1, 0, 0, 8'h00, 3'd0, 0);
    chk_on = 1'b1;
    chk("rst_state", 32'(ifa.fault_state), 32'd0);
    chk("rst_err",   32'(ifa.err_count),   32'd0);
    chk("rst_capv",  32'(ifa.cap_valid),   32'd0);
    chk("rst_mis",   32'(ifa.mismatch),    32'd0);
    apply(0, 1, 0, 8'b0010_1100, 3'd5, 1);
    chk("match_mis",   32'(ifa.mismatch),       32'd0);
    chk("match_state", 32'(ifa.fault_state),    32'd0);
    chk("match_err",   32'(ifa.err_count),      32'd0);
    chk("match_fd",    32'(ifa.fault_detected), 32'd0);

    // Persistence
    apply(0, 1, 0, 8'h80, 3'd3, 1);
    chk("pers1_state", 32'(ifa.fault_state),    32'd1);
    chk("pers1_fd",    32'(ifa.fault_detected), 32'd0);
    apply(0, 1, 0, 8'h80, 3'd3, 1);
    chk("pers2_fd",    32'(ifa.fault_detected), 32'd1);
    chk("pers2_capd",  32'(ifa.cap_d),          32'h80);
    chk("pers2_capyd", 32'(ifa.cap_y_dut),      32'd3);
    chk("pers2_capyg", 32'(ifa.cap_y_gold),     32'd7);
    chk("pers2_err",   32'(ifa.err_count),      32'd2);

    // Run broken by a match
    apply(1, 0, 0, 8'h00, 3'd0, 0);
    apply(0, 1, 0, 8'h80, 3'd3, 1);
    apply(0, 1, 0, 8'h2C, 3'd5, 1);
    apply(0, 1, 0, 8'h80, 3'd3, 1);
    chk("broken_state", 32'(ifa.fault_state), 32'd1);
    chk("broken_err",   32'(ifa.err_count),   32'd2);
    apply(0, 1, 0, 8'h2C, 3'd5, 1);
    chk("broken_ok",    32'(ifa.fault_state), 32'd0);

    // en gaps neither break nor extend the run
    apply(0, 1, 0, 8'h01, 3'd1, 1);
    for (int i = 0; i < 5; i++) apply(0, 0, 0, 8'h55, 3'd0, 0);
    chk("gap_state", 32'(ifa.fault_state), 32'd1);
    chk("gap_mis",   32'(ifa.mismatch),    32'd1);
    apply(0, 1, 0, 8'h01, 3'd1, 1);
    chk("gap_fault", 32'(ifa.fault_state), 32'd2);
    chk("gap_capd",  32'(ifa.cap_d),       32'h01);
    chk("gap_capyg", 32'(ifa.cap_y_gold),  32'd0);
    chk("gap_err",   32'(ifa.err_count),   32'd4);

    // Clear beats a coincident mismatch
    apply(0, 1, 1, 8'h01, 3'd1, 1);
    chk("clr_state", 32'(ifa.fault_state), 32'd0);
    chk("clr_err",   32'(ifa.err_count),   32'd5);
    chk("clr_mis",   32'(ifa.mismatch),    32'd1);

    // Second fault keeps the first capture
    apply(0, 1, 0, 8'h10, 3'd0, 1);
    apply(0, 1, 0, 8'h10, 3'd0, 1);
    chk("sticky_state", 32'(ifa.fault_state), 32'd2);
    chk("sticky_capd",  32'(ifa.cap_d),       32'h01);
    chk("sticky_capyd", 32'(ifa.cap_y_dut),   32'd1);

    // Valid-only fault and zero input
    apply(0, 0, 1, 8'h00, 3'd0, 0);
    chk("clr2_state", 32'(ifa.fault_state), 32'd0);
    apply(0, 1, 0, 8'h00, 3'd0, 1);
    chk("zero_v1_mis", 32'(ifa.mismatch), 32'd1);
    apply(0, 1, 0, 8'h00, 3'd6, 0);
    chk("zero_v0_mis", 32'(ifa.mismatch), 32'd0);

    // Saturation (3-bit counter) then reset while in FAULT
    apply(1, 0, 0, 8'h00, 3'd0, 0);
    for (int i = 0; i < 10; i++) apply(0, 1, 0, 8'h80, 3'd3, 1);
    chk("sat_b_err", 32'(ifb.err_count), 32'd7);
    chk("sat_a_err", 32'(ifa.err_count), 32'd10);
    apply(0, 1, 0, 8'h80, 3'd3, 1);
    apply(0, 1, 0, 8'h80, 3'd3, 1);
    chk("sat_b_hold", 32'(ifb.err_count), 32'd7);
    chk("sat_state",  32'(ifa.fault_state), 32'd2);
    apply(1, 1, 0, 8'h80, 3'd3, 1);
    chk("rstf_state", 32'(ifa.fault_state),    32'd0);
    chk("rstf_fd",    32'(ifa.fault_detected), 32'd0);
    chk("rstf_err",   32'(ifa.err_count),      32'd0);
    chk("rstf_capv",  32'(ifa.cap_valid),      32'd0);
    chk("rstf_capd",  32'(ifa.cap_d),          32'd0);
    chk("rstf_mis",   32'(ifa.mismatch),       32'd0);
    chk("rstf_b_err", 32'(ifb.err_count),      32'd0);

    // Randomized traffic checked against the model every cycle
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) rd = 8'h00;
      else rd = 8'($urandom) >> $urandom_range(0, 7);
      if ($urandom_range(0, 2) != 0) begin
        ry = 3'(gold_idx(rd));
        rv = (rd != 8'h00);
      end else begin
        ry = 3'($urandom_range(0, 7));
        rv = 1'($urandom_range(0, 1));
      end
      apply($urandom_range(0, 149) == 0, $urandom_range(0, 99) < 75,
            $urandom_range(0, 9) == 0, rd, ry, rv);
    end

    @(negedge clk);
    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
